// File: rtl/rtc_fields_pkg.sv
// Shared constants for the BCD field bank: field indices, per-field limits,
// reset values, RTC capture order and the capture FSM state type.
package rtc_fields_pkg;

    localparam int unsigned NUM_STD_FIELDS = 9;

    localparam int unsigned FLD_HOURS   = 0;
    localparam int unsigned FLD_MIN     = 1;
    localparam int unsigned FLD_SEC     = 2;
    localparam int unsigned FLD_MONTH   = 3;
    localparam int unsigned FLD_DAY     = 4;
    localparam int unsigned FLD_YEAR    = 5;
    localparam int unsigned FLD_T_HOURS = 6;
    localparam int unsigned FLD_T_MIN   = 7;
    localparam int unsigned FLD_T_SEC   = 8;

    typedef logic [7:0] bcd_t;

    localparam bcd_t FIELD_MIN [NUM_STD_FIELDS] = '{
        8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00
    };
    localparam bcd_t FIELD_MAX [NUM_STD_FIELDS] = '{
        8'h23, 8'h59, 8'h59, 8'h12, 8'h31, 8'h99, 8'h23, 8'h59, 8'h59
    };
    localparam bcd_t FIELD_RST [NUM_STD_FIELDS] = '{
        8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00
    };
    // RTC burst byte k lands in field CAP_ORDER[k] (sec, min, hours, day, month, ...).
    localparam int unsigned CAP_ORDER [NUM_STD_FIELDS] = '{
        2, 1, 0, 4, 3, 5, 8, 7, 6
    };

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StCommit
    } cap_state_e;

    // Fields beyond the standard nine behave as plain 00-99 counters.
    function automatic bcd_t field_min(input int unsigned f);
        if (f < NUM_STD_FIELDS) return FIELD_MIN[f[3:0]];
        return 8'h00;
    endfunction

    function automatic bcd_t field_max(input int unsigned f);
        if (f < NUM_STD_FIELDS) return FIELD_MAX[f[3:0]];
        return 8'h99;
    endfunction

    function automatic bcd_t field_rst(input int unsigned f);
        if (f < NUM_STD_FIELDS) return FIELD_RST[f[3:0]];
        return 8'h00;
    endfunction

    function automatic int unsigned cap_order(input int unsigned k);
        if (k < NUM_STD_FIELDS) return CAP_ORDER[k[3:0]];
        return k;
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational two-digit BCD step unit: wrapped increment/decrement within
// [min, max] plus a validity check of the presented value.
module bcd_field_step (
    input  logic [7:0] value_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [7:0] next_o,
    output logic       valid_o
);

    logic [7:0] bcd_inc;
    logic [7:0] bcd_dec;

    // Digit-wise carry/borrow; packed BCD compares correctly as binary.
    always_comb begin
        bcd_inc = (value_i[3:0] == 4'd9) ? {value_i[7:4] + 4'd1, 4'd0}
                                         : {value_i[7:4], value_i[3:0] + 4'd1};
        bcd_dec = (value_i[3:0] == 4'd0) ? {value_i[7:4] - 4'd1, 4'd9}
                                         : {value_i[7:4], value_i[3:0] - 4'd1};
        valid_o = (value_i[7:4] <= 4'd9) && (value_i[3:0] <= 4'd9) &&
                  (value_i >= min_i) && (value_i <= max_i);
        next_o  = value_i;
        if (up_i && !down_i) begin
            next_o = (value_i == max_i) ? min_i : bcd_inc;
        end else if (down_i && !up_i) begin
            next_o = (value_i == min_i) ? max_i : bcd_dec;
        end
    end

endmodule

// File: rtl/bcd_field_bank.sv
// Bank of two-digit BCD time/date/timer fields, edited from the keypad or
// loaded atomically from an RTC read burst via a shadow copy.
module bcd_field_bank
    import rtc_fields_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 9,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    W_R,
    input  logic [IDX_W-1:0]        sel,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    dig_we,
    input  logic                    dig_pos,
    input  logic [3:0]              dig_in,
    input  logic                    clr_dirty,
    input  logic                    cap_start,
    input  logic                    cap_valid,
    input  logic [7:0]              cap_byte,
    output logic [8*NUM_FIELDS-1:0] fields_o,
    output logic [NUM_FIELDS-1:0]   edit_dirty,
    output logic                    cap_busy,
    output logic                    cap_done,
    output logic                    cap_err
);

    cap_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             fields_q [NUM_FIELDS];
    logic [7:0]             fields_d [NUM_FIELDS];
    logic [7:0]             shadow_q [NUM_FIELDS];
    logic [7:0]             shadow_d [NUM_FIELDS];
    logic [NUM_FIELDS-1:0]  dirty_q, dirty_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic        sel_ok, capturing;
    logic [7:0]  sel_val, sel_min, sel_max, cand;
    int unsigned tgt;
    logic [7:0]  step_value, step_min, step_max, step_next;
    logic        step_up, step_down, step_valid;
    logic        edit_apply;
    logic [7:0]  edit_val;

    // Selected-field lookup and operand muxing for the shared step unit.
    always_comb begin
        sel_val = 8'h00;
        sel_min = 8'h00;
        sel_max = 8'h00;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (32'(sel) == i) begin
                sel_val = fields_q[i];
                sel_min = field_min(i);
                sel_max = field_max(i);
            end
        end
        sel_ok    = (32'(sel) < NUM_FIELDS);
        capturing = (state_q == StCapture);
        tgt       = cap_order(32'(idx_q));
        cand      = dig_pos ? {dig_in, sel_val[3:0]} : {sel_val[7:4], dig_in};
        // In capture the unit only validates the incoming RTC byte.
        step_value = capturing ? cap_byte : (dig_we ? cand : sel_val);
        step_min   = capturing ? field_min(tgt) : sel_min;
        step_max   = capturing ? field_max(tgt) : sel_max;
        step_up    = !capturing && !dig_we && inc;
        step_down  = !capturing && !dig_we && dec;
    end

    bcd_field_step u_step (
        .value_i (step_value),
        .min_i   (step_min),
        .max_i   (step_max),
        .up_i    (step_up),
        .down_i  (step_down),
        .next_o  (step_next),
        .valid_o (step_valid)
    );

    // Next-state logic for edits, capture FSM, shadow and flags.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fields_d   = fields_q;
        shadow_d   = shadow_q;
        dirty_d    = dirty_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        edit_apply = 1'b0;
        edit_val   = sel_val;

        if (clr_dirty) begin
            dirty_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (!W_R) begin
                    if (sel_ok) begin
                        if (dig_we) begin
                            if (step_valid) begin
                                edit_apply = 1'b1;
                                edit_val   = cand;
                            end
                        end else if (inc ^ dec) begin
                            edit_apply = 1'b1;
                            edit_val   = step_next;
                        end
                    end
                    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                        if (edit_apply && (32'(sel) == i)) begin
                            fields_d[i] = edit_val;
                            dirty_d[i]  = 1'b1;
                        end
                    end
                end else if (cap_start) begin
                    shadow_d = fields_q;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                if (!W_R) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (cap_start) begin
                    shadow_d = fields_q;
                    idx_d    = '0;
                    err_d    = 1'b0;
                end else if (cap_valid) begin
                    if (step_valid) begin
                        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                            if (i == tgt) shadow_d[i] = cap_byte;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (32'(idx_q) == NUM_FIELDS - 1) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                fields_d = shadow_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous return to reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dirty_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                fields_q[i] <= field_rst(i);
                shadow_q[i] <= field_rst(i);
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fields_q <= fields_d;
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_pack
        assign fields_o[8*g +: 8] = fields_q[g];
    end

    assign edit_dirty = dirty_q;
    assign cap_busy   = busy_q;
    assign cap_done   = done_q;
    assign cap_err    = err_q;

endmodule

// File: tb/tb_bcd_field_bank.sv
// Directed self-checking bench for bcd_field_bank.
module tb_bcd_field_bank;

    localparam int unsigned NF = 9;

    logic          clk;
    logic          rst;
    logic          W_R;
    logic [3:0]    sel;
    logic          inc, dec, dig_we, dig_pos;
    logic [3:0]    dig_in;
    logic          clr_dirty, cap_start, cap_valid;
    logic [7:0]    cap_byte;
    logic [8*NF-1:0] fields_o;
    logic [NF-1:0] edit_dirty;
    logic          cap_busy, cap_done, cap_err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int done_base;

    logic [7:0] exp_f [NF];
    logic [7:0] b1 [NF];
    logic [7:0] b2 [NF];
    logic [7:0] b3 [NF];
    logic [7:0] b4 [NF];

    bcd_field_bank #(.NUM_FIELDS(NF), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .W_R        (W_R),
        .sel        (sel),
        .inc        (inc),
        .dec        (dec),
        .dig_we     (dig_we),
        .dig_pos    (dig_pos),
        .dig_in     (dig_in),
        .clr_dirty  (clr_dirty),
        .cap_start  (cap_start),
        .cap_valid  (cap_valid),
        .cap_byte   (cap_byte),
        .fields_o   (fields_o),
        .edit_dirty (edit_dirty),
        .cap_busy   (cap_busy),
        .cap_done   (cap_done),
        .cap_err    (cap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count commit pulses, sampled mid-cycle.
    always @(negedge clk) if (cap_done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_fields(input string tag);
        for (int i = 0; i < NF; i++) begin
            check_eq($sformatf("%s_f%0d", tag, i), 32'(fields_o[8*i +: 8]), 32'(exp_f[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic edit(input logic [3:0] s, input logic i_inc, input logic i_dec,
                        input logic we, input logic pos, input logic [3:0] d);
        sel = s; inc = i_inc; dec = i_dec; dig_we = we; dig_pos = pos; dig_in = d;
        cycle();
        inc = 1'b0; dec = 1'b0; dig_we = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bytes [NF], input int n);
        for (int k = 0; k < n; k++) begin
            cap_valid = 1'b1;
            cap_byte  = bytes[k];
            cycle();
        end
        cap_valid = 1'b0;
    endtask

    task automatic start_burst();
        cap_start = 1'b1;
        cycle();
        cap_start = 1'b0;
    endtask

    task automatic load_exp(input logic [7:0] bytes [NF]);
        // Burst byte order: sec, min, hours, day, month, year, tsec, tmin, thours.
        exp_f[2] = bytes[0]; exp_f[1] = bytes[1]; exp_f[0] = bytes[2];
        exp_f[4] = bytes[3]; exp_f[3] = bytes[4]; exp_f[5] = bytes[5];
        exp_f[8] = bytes[6]; exp_f[7] = bytes[7]; exp_f[6] = bytes[8];
    endtask

    initial begin
        b1 = '{8'h30, 8'h15, 8'h12, 8'h25, 8'h04, 8'h16, 8'h00, 8'h10, 8'h01};
        b2 = '{8'h7A, 8'h20, 8'h25, 8'h31, 8'h09, 8'h99, 8'h59, 8'h58, 8'h23};
        b3 = '{8'h60, 8'h11, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        b4 = '{8'h00, 8'h00, 8'h23, 8'h01, 8'h12, 8'h00, 8'h59, 8'h59, 8'h23};

        rst = 1'b1; W_R = 1'b0; sel = '0; inc = 0; dec = 0; dig_we = 0; dig_pos = 0;
        dig_in = '0; clr_dirty = 0; cap_start = 0; cap_valid = 0; cap_byte = '0;
        repeat (3) cycle();
        exp_f = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        check_fields("rst_in");
        rst = 1'b0;
        cycle();
        check_fields("rst");
        check_eq("rst_dirty", 32'(edit_dirty), 32'h0);
        check_eq("rst_busy", 32'(cap_busy), 32'h0);
        check_eq("rst_done", 32'(cap_done), 32'h0);
        check_eq("rst_err", 32'(cap_err), 32'h0);

        // Min field: digit entry to 0x59, then increment wraps to 0x00.
        edit(4'd1, 0, 0, 1, 1, 4'd5);
        check_eq("min_tens", 32'(fields_o[15:8]), 32'h50);
        edit(4'd1, 0, 0, 1, 0, 4'd9);
        check_eq("min_units", 32'(fields_o[15:8]), 32'h59);
        edit(4'd1, 1, 0, 0, 0, 4'd0);
        check_eq("min_wrap", 32'(fields_o[15:8]), 32'h00);
        check_eq("dirty_min", 32'(edit_dirty), 32'h002);
        clr_dirty = 1'b1; cycle(); clr_dirty = 1'b0;
        check_eq("dirty_clr", 32'(edit_dirty), 32'h000);
        // Set and clear in the same cycle: set wins for that bit.
        clr_dirty = 1'b1; edit(4'd1, 1, 0, 0, 0, 4'd0); clr_dirty = 1'b0;
        check_eq("min_inc", 32'(fields_o[15:8]), 32'h01);
        check_eq("dirty_setwin", 32'(edit_dirty), 32'h002);

        // Month decrement at minimum wraps to 12.
        edit(4'd3, 0, 1, 0, 0, 4'd0);
        check_eq("mon_wrap", 32'(fields_o[31:24]), 32'h12);
        // Hours 09 -> 10 BCD carry.
        edit(4'd0, 0, 0, 1, 0, 4'd9);
        edit(4'd0, 1, 0, 0, 0, 4'd0);
        check_eq("hr_carry", 32'(fields_o[7:0]), 32'h10);
        edit(4'd0, 1, 1, 0, 0, 4'd0);
        check_eq("hr_incdec", 32'(fields_o[7:0]), 32'h10);
        check_eq("dirty_multi", 32'(edit_dirty), 32'h00B);
        // Out-of-range select is ignored.
        edit(4'd9, 1, 0, 0, 0, 4'd0);
        check_eq("sel_oob_dirty", 32'(edit_dirty), 32'h00B);

        // Sec field digit entry with a rejected tens digit.
        edit(4'd2, 0, 0, 1, 0, 4'd5);
        check_eq("sec_units", 32'(fields_o[23:16]), 32'h05);
        edit(4'd2, 0, 0, 1, 1, 4'd6);
        check_eq("sec_reject", 32'(fields_o[23:16]), 32'h05);
        // dig_we outranks inc even when its write is dropped.
        sel = 4'd2; dig_we = 1'b1; dig_pos = 1'b0; dig_in = 4'hA; inc = 1'b1;
        cycle(); dig_we = 1'b0; inc = 1'b0;
        check_eq("sec_prio", 32'(fields_o[23:16]), 32'h05);
        edit(4'd2, 0, 0, 1, 1, 4'd4);
        check_eq("sec_tens", 32'(fields_o[23:16]), 32'h45);

        // Edits ignored in RTC mode.
        W_R = 1'b1;
        edit(4'd0, 1, 0, 0, 0, 4'd0);
        check_eq("wr_ignore", 32'(fields_o[7:0]), 32'h10);

        // Full burst.
        exp_f = '{8'h10, 8'h01, 8'h45, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        done_base = done_cnt;
        start_burst();
        check_eq("b1_busy", 32'(cap_busy), 32'h1);
        send_bytes(b1, NF);
        check_fields("b1_pre");
        check_eq("b1_pre_done", 32'(cap_done), 32'h0);
        cycle();
        load_exp(b1);
        check_fields("b1");
        check_eq("b1_done", 32'(cap_done), 32'h1);
        check_eq("b1_busy_end", 32'(cap_busy), 32'h0);
        check_eq("b1_err", 32'(cap_err), 32'h0);
        cycle();
        check_eq("b1_done_cnt", 32'(done_cnt - done_base), 32'h1);

        // Burst with rejected bytes for sec (0x7A) and hours (0x25).
        start_burst();
        send_bytes(b2, NF);
        cycle();
        load_exp(b2);
        exp_f[2] = 8'h30;
        exp_f[0] = 8'h12;
        check_fields("b2");
        repeat (2) cycle();
        check_eq("b2_err_sticky", 32'(cap_err), 32'h1);

        // Abort after four bytes, one rejected: no commit, error retained.
        done_base = done_cnt;
        start_burst();
        check_eq("ab_err_clr", 32'(cap_err), 32'h0);
        send_bytes(b3, 4);
        W_R = 1'b0;
        cycle();
        check_eq("ab_busy", 32'(cap_busy), 32'h0);
        repeat (3) cycle();
        check_fields("ab");
        check_eq("ab_err", 32'(cap_err), 32'h1);
        check_eq("ab_done_cnt", 32'(done_cnt - done_base), 32'h0);

        // Restart mid-burst; the byte presented with the restart is dropped.
        W_R = 1'b1;
        done_base = done_cnt;
        start_burst();
        send_bytes(b2, 3);
        cap_start = 1'b1; cap_valid = 1'b1; cap_byte = 8'h33;
        cycle();
        cap_start = 1'b0; cap_valid = 1'b0;
        check_eq("rs_err_clr", 32'(cap_err), 32'h0);
        check_eq("rs_busy", 32'(cap_busy), 32'h1);
        send_bytes(b4, NF);
        check_fields("rs_pre");
        cycle();
        load_exp(b4);
        check_fields("rs");
        repeat (2) cycle();
        check_eq("rs_done_cnt", 32'(done_cnt - done_base), 32'h1);

        // Asynchronous reset mid-burst.
        start_burst();
        send_bytes(b1, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_busy", 32'(cap_busy), 32'h0);
        check_eq("ar_hr", 32'(fields_o[7:0]), 32'h00);
        check_eq("ar_day", 32'(fields_o[39:32]), 32'h01);
        cycle();
        rst = 1'b0;
        W_R = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_field_bank.md
# bcd_field_bank

Parametrised successor to the per-digit unit registers: a bank of `NUM_FIELDS` two-digit packed-BCD time/date/timer fields. Each field is written either by user editing or by an atomic burst captured from the RTC read path. User editing covers increment/decrement with per-field wrap limits, and direct digit entry. It sits between the keypad/edit controller and the display/RTC write formatter, and replaces per-unit digit decoding with validated whole-field storage.

## Interface
- `NUM_FIELDS`, default 9: number of fields. Field order is 0 hours, 1 min, 2 sec, 3 month, 4 day, 5 year, 6 timer hours, 7 timer min, 8 timer sec.
- `IDX_W`, default 4: width of field index; must satisfy 2^IDX_W ≥ NUM_FIELDS.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `W_R`  in  1  0 = user edit mode, 1 = RTC capture mode.
- `sel`  in  IDX_W  field targeted by edits.
- `inc`, `dec`  in  1  single-cycle edit pulses.
- `dig_we`  in  1  direct digit write strobe.
- `dig_pos`  in  1  0 = units nibble, 1 = tens nibble.
- `dig_in`  in  4  digit value for `dig_we`.
- `clr_dirty`  in  1  clears `edit_dirty`.
- `cap_start`  in  1  begins a capture burst.
- `cap_valid`  in  1  `cap_byte` qualifier.
- `cap_byte`  in  8  packed BCD byte from the RTC.
- `fields_o`  out  8*NUM_FIELDS  live fields, field i at [8i+7:8i].
- `edit_dirty`  out  NUM_FIELDS  per-field "edited since clear" mask.
- `cap_busy`  out  1  capture in progress.
- `cap_done`  out  1  one-cycle pulse on commit.
- `cap_err`  out  1  sticky flag: a rejected byte occurred in the current or last burst.

## Operation
- **Validity.** A byte is valid for field f iff both nibbles ≤ 9 and FIELD_MIN[f] ≤ value ≤ FIELD_MAX[f].
  - Limits: hours/timer hours 0–23, min/sec 0–59, month 1–12, day 1–31, year 0–99.
- **FSM.** States IDLE, CAPTURE, COMMIT.
- **IDLE, W_R=0 (edit).** Only when `sel` < NUM_FIELDS; otherwise the edit is ignored.
  - Priority: `dig_we` > `inc`/`dec`. `inc`&`dec` together: no change.
  - `inc`: at max, wrap to min; otherwise BCD +1 (units 9 → units 0, tens +1).
  - `dec`: at min, wrap to max; otherwise BCD −1 (units 0 → units 9, tens −1).
  - `dig_we`: replace the selected nibble; if the result is invalid, the write is dropped.
  - Any applied edit sets `edit_dirty[sel]`. A set in the same cycle as `clr_dirty` wins for that bit.
- **IDLE, W_R=1.** Edit inputs are ignored. `cap_start` starts capture:
  - copies live fields into the shadow;
  - clears idx and `cap_err`;
  - moves the FSM to CAPTURE.
- **CAPTURE.** Each `cap_valid` byte k targets field CAP_ORDER[k] (default order 2,1,0,4,3,5,8,7,6).
  - A valid byte writes the shadow.
  - An invalid byte leaves the shadow unchanged and sets `cap_err`.
  - idx increments on every byte. The byte with idx = NUM_FIELDS−1 moves the FSM to COMMIT.
- **COMMIT.** Live fields ← shadow, `cap_done` pulses, return to IDLE. `edit_dirty` is unaffected.
- **`cap_start` during CAPTURE.** Restarts the burst: shadow reloaded, idx=0, `cap_err` cleared.
- **W_R→0 during CAPTURE.** Abort to IDLE with no commit; live fields unchanged; `cap_err` retained.
- **Reset.**
  - All fields 0x00 except month and day, which are 0x01.
  - `edit_dirty`=0, `cap_busy`=0, `cap_done`=0, `cap_err`=0.
  - FSM in IDLE, idx=0, shadow = reset values.

## Timing
- An edit sampled at edge E is visible on `fields_o` after E.
- `cap_busy` is registered: high from the edge sampling `cap_start` until the edge leaving COMMIT.
- Commit latency: last byte sampled at edge E → FSM in COMMIT after E → at E+1, `fields_o` updates and `cap_done`=1 for exactly one cycle.
- `cap_valid` may be asserted back-to-back every cycle. There is no backpressure.
- `cap_valid` in IDLE or COMMIT is ignored.
- A `cap_start` and `cap_valid` in the same cycle: the start wins and the byte is dropped.
- Reset mid-burst returns all state to reset values asynchronously, with no commit.

## Structure
- Package `rtc_fields_pkg`:
  - field index constants;
  - FIELD_MIN/FIELD_MAX arrays;
  - CAP_ORDER array;
  - reset value array;
  - FSM state enum.
- Sub-module `bcd_field_step`: combinational; inputs value, min, max, up/down; outputs the wrapped BCD next value and a valid flag. One instance serves the selected field. The validity check is reused for capture bytes.

## Test plan
- **Reset values:** assert `rst` → `fields_o` all 0x00 except fields 3 and 4 = 0x01; all flags 0.
- **Increment wrap:** field 1 = 0x59, `inc` → 0x00, `edit_dirty`[1]=1. Field 3 = 0x01, `dec` → 0x12. Field 0 = 0x09, `inc` → 0x10.
- **Digit entry:** `sel`=2 at 0x05, `dig_we`, `dig_pos`=1, `dig_in`=6 → rejected, stays 0x05. `dig_in`=4 → 0x45.
- **Full burst:** W_R=1, `cap_start`, then 9 back-to-back bytes 0x30,0x15,0x12,0x25,0x04,0x16,0x00,0x10,0x01.
  - Fields stay unchanged until E+1.
  - Then field 2=0x30, field 1=0x15, field 0=0x12, field 4=0x25, field 3=0x04, field 5=0x16, field 8=0x00, field 7=0x10, field 6=0x01.
  - `cap_done` pulses once.
- **Rejected bytes:** a burst with byte 2 = 0x25 and byte 0 = 0x7A → fields 0 and 2 keep their prior values, all other fields update, `cap_err`=1 until the next `cap_start`.
- **Abort and restart:** W_R→0 after 4 bytes → no field changes and no `cap_done`. A `cap_start` mid-burst restarts from idx 0, and only the second burst commits.
